// File: rtl/car_motion_sequencer.sv
// Timed motion command queue driving the servo direction code.
// Inserts a STOP gap on back-to-back direction reversals.
module car_motion_sequencer #(
  parameter int TICK_DIV  = 100_000,
  parameter int GAP_TICKS = 50,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_dir,
  input  logic [15:0]              cmd_time,
  output logic                     cmd_ready,
  input  logic                     abort,
  output logic [1:0]               dir,
  output logic                     busy,
  output logic                     cmd_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, GAP, RUN} state_t;

  state_t state, n_state;

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    cur_dir, n_cur;
  logic [15:0]   cur_time, n_time;
  logic [1:0]    last_dir, n_last;
  logic [TW-1:0] tick, n_tick;
  logic [15:0]   rem, n_rem;
  logic          n_done, pop, push, start, tick_end;
  logic [1:0]    hd_dir;
  logic [15:0]   hd_time;

  assign cmd_ready = (level < FULL) && !abort && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign hd_dir    = (mem[rd_ptr][17:16] == 2'b11) ? 2'b00 : mem[rd_ptr][17:16];
  assign hd_time   = mem[rd_ptr][15:0];
  assign tick_end  = (tick == TLAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_dir, cmd_time};
  end

  always_comb begin
    n_state = state;
    n_cur   = cur_dir;
    n_time  = cur_time;
    n_last  = last_dir;
    n_tick  = tick;
    n_rem   = rem;
    n_done  = 1'b0;
    pop     = 1'b0;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          pop = 1'b1;
          // zero-length commands retire straight from IDLE
          if (hd_time == '0) n_done = 1'b1;
          else start = 1'b1;
        end
      end
      GAP: begin
        n_tick = tick_end ? '0 : tick + 1'b1;
        if (tick_end) begin
          if (rem == 16'd1) begin
            n_state = RUN;
            n_rem   = cur_time;
            n_last  = cur_dir;
          end else begin
            n_rem = rem - 1'b1;
          end
        end
      end
      RUN: begin
        n_tick = tick_end ? '0 : tick + 1'b1;
        if (tick_end) begin
          if (rem == 16'd1) begin
            n_done = 1'b1;
            if (level != '0 && hd_time != '0) begin
              pop   = 1'b1;
              start = 1'b1;
            end else begin
              n_state = IDLE;
              n_last  = 2'b00;
              n_rem   = '0;
            end
          end else begin
            n_rem = rem - 1'b1;
          end
        end
      end
      default: n_state = IDLE;
    endcase
    if (start) begin
      n_cur  = hd_dir;
      n_time = hd_time;
      n_tick = '0;
      if (last_dir != 2'b00 && hd_dir != 2'b00 && hd_dir != last_dir) begin
        n_state = GAP;
        n_rem   = 16'(GAP_TICKS);
      end else begin
        n_state = RUN;
        n_rem   = hd_time;
        n_last  = hd_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cur_dir  <= 2'b00;
      cur_time <= '0;
      last_dir <= 2'b00;
      tick     <= '0;
      rem      <= '0;
      dir      <= 2'b00;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      state    <= n_state;
      cur_dir  <= n_cur;
      cur_time <= n_time;
      last_dir <= n_last;
      tick     <= n_tick;
      rem      <= n_rem;
      dir      <= (n_state == RUN) ? n_cur : 2'b00;
      busy     <= (n_state != IDLE);
      cmd_done <= n_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_car_motion_sequencer.sv
// Directed bench for car_motion_sequencer.
// Small tick/gap/depth values keep traces short.
module tb_car_motion_sequencer;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, abort;
  logic [1:0]  cmd_dir;
  logic [15:0] cmd_time;
  logic        cmd_ready;
  logic [1:0]  dir;
  logic        busy, cmd_done;
  logic [2:0]  level;

  car_motion_sequencer #(
    .TICK_DIV(4),
    .GAP_TICKS(2),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .cmd_time(cmd_time),
    .cmd_ready(cmd_ready),
    .abort(abort),
    .dir(dir),
    .busy(busy),
    .cmd_done(cmd_done),
    .level(level)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic rec = 1'b0;
  int   tr[$];
  int   dn;

  // trace of {busy,dir}: 0 idle, 4 gap/stop-run, 5 fwd, 6 rev
  always @(negedge clk) begin
    if (rec) begin
      tr.push_back(int'({busy, dir}));
      if (cmd_done) dn++;
    end
  end

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [1:0] d, int t);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_time  = 16'(t);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || level != 0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("idle_timeout", n, 0);
    step();
    step();
  endtask

  task automatic begin_rec();
    tr.delete();
    dn  = 0;
    rec = 1'b1;
  endtask

  task automatic check_runs(string tag, int n, int ec[4], int el[4]);
    int rc[$];
    int rl[$];
    int k;
    rec = 1'b0;
    foreach (tr[i]) begin
      if (rc.size() > 0 && rc[rc.size()-1] == tr[i]) begin
        k = rl.size() - 1;
        rl[k] = rl[k] + 1;
      end else begin
        rc.push_back(tr[i]);
        rl.push_back(1);
      end
    end
    if (rc.size() > 0 && rc[0] == 0) begin
      void'(rc.pop_front());
      void'(rl.pop_front());
    end
    if (rc.size() > 0 && rc[rc.size()-1] == 0) begin
      void'(rc.pop_back());
      void'(rl.pop_back());
    end
    chk({tag, "_nruns"}, rc.size(), n);
    for (int i = 0; i < n && i < rc.size(); i++) begin
      chk($sformatf("%s_code%0d", tag, i), rc[i], ec[i]);
      chk($sformatf("%s_len%0d", tag, i), rl[i], el[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_dir = 2'b00;
    cmd_time = 16'd0;
    step();
    step();
    step();
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    begin_rec();
    push(2'b01, 3);
    wait_idle();
    check_runs("single", 1, '{5, 0, 0, 0}, '{12, 0, 0, 0});
    chk("single_done", dn, 1);

    begin_rec();
    push(2'b01, 2);
    push(2'b10, 1);
    wait_idle();
    check_runs("rev", 3, '{5, 4, 6, 0}, '{8, 8, 4, 0});
    chk("rev_done", dn, 2);

    begin_rec();
    push(2'b01, 1);
    push(2'b01, 1);
    push(2'b00, 1);
    wait_idle();
    check_runs("same", 2, '{5, 4, 0, 0}, '{8, 4, 0, 0});
    chk("same_done", dn, 3);

    begin_rec();
    push(2'b10, 0);
    push(2'b10, 1);
    chk("zero_done", cmd_done, 1);
    chk("zero_dir", dir, 0);
    chk("zero_level", level, 1);
    wait_idle();
    check_runs("zero", 1, '{6, 0, 0, 0}, '{4, 0, 0, 0});
    chk("zero_ndone", dn, 2);

    push(2'b01, 3);
    step();
    chk("full_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_dir   = 2'b01;
      cmd_time  = 16'd1;
      #1;
      chk($sformatf("full_ready%0d", i), cmd_ready, (i < 4) ? 1 : 0);
      step();
    end
    cmd_valid = 1'b0;
    chk("full_level", level, 4);
    for (int k = 3; k >= 0; k--) begin
      int n = 0;
      while (!cmd_done && n < 100) begin
        step();
        n++;
      end
      chk($sformatf("full_done%0d", k), cmd_done, 1);
      chk($sformatf("full_lvl%0d", k), level, k);
      step();
    end
    wait_idle();

    push(2'b01, 5);
    step();
    push(2'b10, 1);
    push(2'b10, 1);
    push(2'b10, 1);
    chk("abort_pre_level", level, 3);
    chk("abort_pre_dir", dir, 1);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 2'b10;
    cmd_time  = 16'd1;
    #1;
    chk("abort_ready", cmd_ready, 0);
    step();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_dir", dir, 0);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", cmd_done, 0);
    step();
    chk("abort_done2", cmd_done, 0);
    chk("abort_level2", level, 0);
    begin_rec();
    push(2'b10, 1);
    wait_idle();
    check_runs("post_abort", 1, '{6, 0, 0, 0}, '{4, 0, 0, 0});

    push(2'b01, 2);
    step();
    chk("mid_rst_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_done", cmd_done, 0);
    step();
    chk("mid_rst_done2", cmd_done, 0);
    chk("mid_rst_dir", dir, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/car_motion_sequencer.md
CAR_MOTION_SEQUENCER -- requirements
Module: car_motion_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100_000, clk cycles per time tick (1 ms at 100 MHz); SHALL be at least 2.
REQ-002 Parameter GAP_TICKS, default 50, number of STOP ticks inserted on a back-to-back direction reversal; SHALL be at least 1.
REQ-003 Parameter DEPTH, default 4, command queue depth; SHALL be a power of 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered this cycle.
REQ-007 cmd_dir  input  2  commanded direction: 00 stop, 01 forward, 10 reverse, 11 treated as 00.
REQ-008 cmd_time  input  16  duration in ticks.
REQ-009 cmd_ready  output  1  queue can accept a command this cycle.
REQ-010 abort  input  1  emergency stop and flush.
REQ-011 dir  output  2  direction code driven to the servo PWM generator (registered).
REQ-012 busy  output  1  high while state is not IDLE (registered).
REQ-013 cmd_done  output  1  one-cycle pulse when a command completes (registered).
REQ-014 level  output  clog2(DEPTH)+1  number of queued commands (registered).

Function
REQ-015 cmd_ready SHALL equal (level < DEPTH) AND NOT abort AND NOT rst.
REQ-016 A command SHALL be pushed when cmd_valid AND cmd_ready are both high; cmd_valid with cmd_ready low SHALL be ignored, with no stall memory.
REQ-017 The queue SHALL be FIFO-ordered; a push and a pop in the same cycle SHALL leave level unchanged.
REQ-018 The FSM SHALL have exactly three states: IDLE, GAP and RUN.
REQ-019 IDLE: dir SHALL be 00; when level > 0, the FSM SHALL pop the head and enter RUN or GAP, with dir updating on the next edge.
REQ-020 A pop SHALL enter GAP only when last_dir and the new dir are both nonzero and differ; otherwise the pop SHALL enter RUN.
REQ-021 last_dir SHALL hold the dir of the last RUN and SHALL be cleared to 00 on entry to IDLE.
REQ-022 GAP: dir SHALL be 00 for exactly GAP_TICKS*TICK_DIV cycles, then the FSM SHALL enter RUN with the popped command.
REQ-023 RUN: dir SHALL hold the command direction (11 mapped to 00) for exactly cmd_time*TICK_DIV cycles.
REQ-024 The tick prescaler SHALL restart at 0 on every entry to GAP or RUN.
REQ-025 RUN completion SHALL pulse cmd_done for one cycle.
REQ-026 On RUN completion with level > 0, the next command SHALL be popped in the same cycle, with no idle cycle between commands.
REQ-027 On RUN completion with level = 0, the FSM SHALL enter IDLE and dir SHALL be 00 on the next cycle.
REQ-028 A command with cmd_time = 0 SHALL be popped without entering RUN (or GAP), SHALL pulse cmd_done once, SHALL leave dir and last_dir unchanged, and SHALL let the next command, if any, pop on the following cycle.
REQ-029 abort SHALL have highest priority: on the next edge the FSM SHALL be in IDLE with level = 0, dir = 00, last_dir = 00, busy = 0 and no cmd_done pulse.
REQ-030 A push coincident with abort SHALL be discarded.
REQ-031 The tick counter SHALL be at least clog2(TICK_DIV) bits and the remaining-tick counter at least 16 bits, with no wrap-around inside a command.

Reset
REQ-032 While rst is high: state = IDLE, level = 0, dir = 00, last_dir = 00, busy = 0, cmd_done = 0, and all counters = 0.
REQ-033 rst asserted mid-command SHALL discard the queue and the active command with no cmd_done pulse.
REQ-034 cmd_ready SHALL be 1 on the first cycle after rst deasserts.

Verification (TICK_DIV=4, GAP_TICKS=2, DEPTH=4)
REQ-035 Push {01, 3} from IDLE -> dir=01 for exactly 12 cycles starting 1 cycle after the pop, then a cmd_done pulse, then dir=00 and busy=0.
REQ-036 Push {01,2} then {10,1} back-to-back -> dir 01 for 8 cycles, 00 for 8 cycles (GAP), 10 for 4 cycles; two cmd_done pulses.
REQ-037 Push {01,1}, {01,1}, {00,1} -> dir 01 for 8 contiguous cycles, then 00 for 4 cycles; no GAP inserted.
REQ-038 With RUN active, push 5 commands -> 4 accepted, cmd_ready=0 while level=4, 5th ignored; level decrements by 1 per completion.
REQ-039 Assert abort for 1 cycle mid-RUN with level=3 -> next cycle dir=00, level=0, busy=0, no cmd_done pulse; a later push starts normally with no GAP.
REQ-040 Push {10,0} then {10,1} -> one cmd_done pulse with dir unchanged, then dir=10 for 4 cycles and a second cmd_done pulse.
